neo_lbwrite: RTL

Line-buffer write stage fed directly by the ZMC2 dot serializer. Each CLK_12M cycle, it takes one pixel pair (GAD/GBD colour codes plus DOTA/DOTB opacity) and tags it with the latched sprite palette. It then writes opaque pixels into the even and odd line-buffer banks at the current screen X. It also provides a whole-line clear sequence, so the buffer that has just been displayed is transparent before it is redrawn.

---
 rtl/neo_lb_pkg.sv | 16 +
 rtl/lb_bank_port.sv | 63 ++++++
 rtl/neo_lbwrite.sv | 118 +++++++++++
 3 files changed

// File: rtl/neo_lb_pkg.sv
// Shared constants and types for the neo line-buffer write stage.
package neo_lb_pkg;
  localparam int LB_DEPTH_DEF = 160;
  localparam int PAIRS_DEF    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    CLR  = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0] pal;
    logic [3:0] col;
  } lb_entry_t;
endpackage

// File: rtl/lb_bank_port.sv
// One line-buffer bank write port: X pointer, visibility gate and registered
// ADDR/DATA/WE stage. Clear writes take precedence over pixel writes.
module lb_bank_port
  import neo_lb_pkg::*;
#(
  parameter int LB_DEPTH = LB_DEPTH_DEF
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        load_i,
  input  logic [7:0]  load_ptr_i,
  input  logic        adv_i,
  input  logic        dot_i,
  input  logic [3:0]  col_i,
  input  logic [7:0]  pal_i,
  input  logic        clr_i,
  input  logic [7:0]  clr_addr_i,
  output logic [7:0]  addr_o,
  output logic [11:0] data_o,
  output logic        we_o
);
  localparam logic [8:0] DEPTH = 9'(LB_DEPTH);

  logic [7:0] ptr_q;
  logic [7:0] addr_q;
  lb_entry_t  data_q;
  logic       we_q;
  logic       visible;

  assign visible = {1'b0, ptr_q} < DEPTH;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
      we_q   <= 1'b0;
    end else begin
      // Pointer wraps 255 -> 0 silently; off-screen positions are simply gated.
      if (load_i)     ptr_q <= load_ptr_i;
      else if (adv_i) ptr_q <= ptr_q + 8'd1;

      if (clr_i) begin
        we_q   <= 1'b1;
        addr_q <= clr_addr_i;
        data_q <= '0;
      end else if (adv_i && dot_i && visible) begin
        we_q       <= 1'b1;
        addr_q     <= ptr_q;
        data_q.pal <= pal_i;
        data_q.col <= col_i;
      end else begin
        we_q   <= 1'b0;
        addr_q <= '0;
        data_q <= '0;
      end
    end
  end

  assign addr_o = addr_q;
  assign data_o = data_q;
  assign we_o   = we_q;
endmodule

// File: rtl/neo_lbwrite.sv
// Line-buffer write stage: tags serializer pixel pairs with the strip palette,
// writes opaque on-screen pixels to the even/odd banks, and clears whole lines.
module neo_lbwrite
  import neo_lb_pkg::*;
#(
  parameter int LB_DEPTH = LB_DEPTH_DEF,
  parameter int PAIRS    = PAIRS_DEF
) (
  input  logic        CLK_12M,
  input  logic        nRESET,
  input  logic        START,
  input  logic [8:0]  XSTART,
  input  logic [7:0]  PAL,
  input  logic        VALID,
  input  logic [3:0]  GAD,
  input  logic [3:0]  GBD,
  input  logic        DOTA,
  input  logic        DOTB,
  input  logic        CLEAR,
  output logic [7:0]  EA_ADDR,
  output logic [7:0]  OA_ADDR,
  output logic [11:0] EA_DATA,
  output logic [11:0] OA_DATA,
  output logic        EA_WE,
  output logic        OA_WE,
  output logic        BUSY,
  output logic        DONE
);
  localparam int CW = $clog2(PAIRS + 1);

  state_t        state_q;
  logic [CW-1:0] pair_cnt_q;
  logic [7:0]    clr_cnt_q;
  logic [7:0]    pal_q;
  logic          busy_q;
  logic          done_q;

  logic       load, accept, clr_wr, last_pair, last_clr;
  logic [7:0] eptr_ld, optr_ld, clr_addr;

  // Even bank starts at the first even pixel at or after XSTART.
  assign eptr_ld   = XSTART[8:1] + {7'd0, XSTART[0]};
  assign optr_ld   = XSTART[8:1];
  assign load      = START && (state_q != CLR);
  assign accept    = (state_q == DRAW) && VALID && !START;
  assign clr_wr    = ((state_q == IDLE) && CLEAR && !START) || (state_q == CLR);
  assign clr_addr  = (state_q == CLR) ? clr_cnt_q : 8'd0;
  assign last_pair = accept && (pair_cnt_q == CW'(PAIRS - 1));
  assign last_clr  = (state_q == CLR) && (clr_cnt_q == 8'(LB_DEPTH - 1));

  always_ff @(posedge CLK_12M or negedge nRESET) begin
    if (!nRESET) begin
      state_q    <= IDLE;
      pair_cnt_q <= '0;
      clr_cnt_q  <= '0;
      pal_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // BUSY stays up through the cycle that shows the final write.
      busy_q <= (state_q != IDLE) || START || CLEAR;
      unique case (state_q)
        IDLE: begin
          if (START) begin
            state_q    <= DRAW;
            pal_q      <= PAL;
            pair_cnt_q <= '0;
          end else if (CLEAR) begin
            state_q   <= CLR;
            clr_cnt_q <= 8'd1;
          end
        end
        DRAW: begin
          if (START) begin
            pal_q      <= PAL;
            pair_cnt_q <= '0;
          end else if (accept) begin
            if (last_pair) begin
              state_q    <= IDLE;
              done_q     <= 1'b1;
              pair_cnt_q <= '0;
            end else begin
              pair_cnt_q <= pair_cnt_q + CW'(1);
            end
          end
        end
        CLR: begin
          if (last_clr) begin
            state_q   <= IDLE;
            done_q    <= 1'b1;
            clr_cnt_q <= '0;
          end else begin
            clr_cnt_q <= clr_cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  lb_bank_port #(.LB_DEPTH(LB_DEPTH)) u_even (
    .clk_i(CLK_12M), .rst_n_i(nRESET), .load_i(load), .load_ptr_i(eptr_ld),
    .adv_i(accept), .dot_i(DOTA), .col_i(GAD), .pal_i(pal_q),
    .clr_i(clr_wr), .clr_addr_i(clr_addr),
    .addr_o(EA_ADDR), .data_o(EA_DATA), .we_o(EA_WE)
  );

  lb_bank_port #(.LB_DEPTH(LB_DEPTH)) u_odd (
    .clk_i(CLK_12M), .rst_n_i(nRESET), .load_i(load), .load_ptr_i(optr_ld),
    .adv_i(accept), .dot_i(DOTB), .col_i(GBD), .pal_i(pal_q),
    .clr_i(clr_wr), .clr_addr_i(clr_addr),
    .addr_o(OA_ADDR), .data_o(OA_DATA), .we_o(OA_WE)
  );

  assign BUSY = busy_q;
  assign DONE = done_q;
endmodule
